// File: rtl/user_proj_example.sv
// Caravel user-area wrapper around a 16x16 Morphle Logic cell array driven from the LA pins.
// Optional MORPHLE_VOUT_REG_EN registers the bottom-edge vout bus on wb_clk_i.
module user_proj_example (
    inout  wire          vdda1,
    inout  wire          vdda2,
    inout  wire          vssa1,
    inout  wire          vssa2,
    inout  wire          vccd1,
    inout  wire          vccd2,
    inout  wire          vssd1,
    inout  wire          vssd2,
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         wbs_stb_i,
    input  logic         wbs_cyc_i,
    input  logic         wbs_we_i,
    input  logic [3:0]   wbs_sel_i,
    input  logic [31:0]  wbs_dat_i,
    input  logic [31:0]  wbs_adr_i,
    output logic         wbs_ack_o,
    output logic [31:0]  wbs_dat_o,
    input  logic [127:0] la_data_in,
    output logic [127:0] la_data_out,
    input  logic [127:0] la_oen,
    input  logic [37:0]  io_in,
    output logic [37:0]  io_out,
    output logic [37:0]  io_oeb
);

    localparam int ROWS  = 16;
    localparam int COLS  = 16;
    localparam int CHAIN = 3 * ROWS;

    localparam logic [1:0] DR_EMPTY = 2'b00;
    localparam logic [1:0] DR_ZERO  = 2'b01;
    localparam logic [1:0] DR_ONE   = 2'b10;

    function automatic logic [1:0] dr_norm(input logic [1:0] x);
        return (x == 2'b11) ? DR_EMPTY : x;
    endfunction

    function automatic logic [1:0] dr_and(input logic [1:0] a, input logic [1:0] b);
        if (a == DR_EMPTY || b == DR_EMPTY)
            return DR_EMPTY;
        else if (a == DR_ONE && b == DR_ONE)
            return DR_ONE;
        else
            return DR_ZERO;
    endfunction

    logic [COLS-1:0][1:0]       vin;
    logic [COLS-1:0]            cbitin;
    logic                       cfg_shift;
    logic                       cfg_clear;
    logic [COLS-1:0][CHAIN-1:0] cfg_q;
    logic [COLS-1:0][1:0]       vout_comb;
    logic [COLS-1:0][1:0]       vout;
    logic [COLS-1:0]            cbitout;

    assign vin       = la_data_in[95:64];
    assign cbitin    = la_data_in[111:96];
    assign cfg_shift = la_data_in[112];
    assign cfg_clear = la_data_in[113];

    // Chain position 3r+k holds bit k of row r, so position CHAIN-1 is row 15's b2.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cfg_q <= '0;
        end else if (cfg_clear) begin
            cfg_q <= '0;
        end else if (cfg_shift) begin
            for (int c = 0; c < COLS; c++)
                cfg_q[c] <= {cfg_q[c][CHAIN-2:0], cbitin[c]};
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cbit
        assign cbitout[c] = cfg_q[c][CHAIN-1];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [2:0] cell_type;
            logic [1:0] vi;
            logic [1:0] hi;
            logic [1:0] vi_n;
            logic [1:0] hi_n;
            logic [1:0] vo;
            logic [1:0] ho;

            assign cell_type = cfg_q[c][3*r +: 3];

            if (r == 0) begin : g_top
                assign vi = vin[c];
            end else begin : g_inner_v
                assign vi = g_row[r-1].g_col[c].vo;
            end

            if (c == 0) begin : g_left
                assign hi = DR_ONE;
            end else begin : g_inner_h
                assign hi = g_row[r].g_col[c-1].ho;
            end

            always_comb begin
                vi_n = dr_norm(vi);
                hi_n = dr_norm(hi);
                vo   = DR_EMPTY;
                ho   = DR_EMPTY;
                case (cell_type)
                    3'd1: vo = vi_n;
                    3'd2: ho = hi_n;
                    3'd3: begin
                        vo = vi_n;
                        ho = hi_n;
                    end
                    3'd4: begin
                        vo = vi_n;
                        ho = dr_and(hi_n, vi_n);
                    end
                    3'd5: begin
                        vo = vi_n;
                        ho = dr_and(hi_n, {vi_n[0], vi_n[1]});
                    end
                    3'd6: begin
                        vo = hi_n;
                        ho = hi_n;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_bottom
        assign vout_comb[c] = g_row[ROWS-1].g_col[c].vo;
    end

`ifdef MORPHLE_VOUT_REG_EN
    logic [COLS-1:0][1:0] vout_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            vout_q <= '0;
        else if (cfg_clear)
            vout_q <= '0;
        else
            vout_q <= vout_comb;
    end

    assign vout = vout_q;
`else
    assign vout = vout_comb;
`endif

    assign la_data_out = {80'd0, cbitout, vout};
    assign wbs_ack_o   = 1'b0;
    assign wbs_dat_o   = '0;
    assign io_out      = '0;
    assign io_oeb      = '1;

    // Harness-only pins are gathered here so they are visibly intentionally unused.
    logic unused_inputs;
    assign unused_inputs = ^{wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
                             wbs_adr_i, la_data_in[127:114], la_data_in[63:0], la_oen,
                             io_in, vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2};

endmodule

// File: tb/tb_user_proj_example.sv
// Directed bench for user_proj_example: reset, wire loading, clear priority, logic cells, hold and mid-load reset.
module tb_user_proj_example;

    wire vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2;
    assign vdda1 = 1'b1;
    assign vdda2 = 1'b1;
    assign vccd1 = 1'b1;
    assign vccd2 = 1'b1;
    assign vssa1 = 1'b0;
    assign vssa2 = 1'b0;
    assign vssd1 = 1'b0;
    assign vssd2 = 1'b0;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  vin;
    logic [15:0]  cbitin;
    logic         cfg_shift;
    logic         cfg_clear;
    logic [13:0]  ign_hi;
    logic [63:0]  ign_lo;
    logic [127:0] la_data_in;
    logic [127:0] la_data_out;
    logic         wbs_ack;
    logic [31:0]  wbs_dat;
    logic [37:0]  io_out;
    logic [37:0]  io_oeb;

    logic [31:0]  vout;
    logic [15:0]  cbitout;
    logic [2:0]   types [16][16];

    int errors = 0;
    int checks = 0;

    assign la_data_in = {ign_hi, cfg_clear, cfg_shift, cbitin, vin, ign_lo};
    assign vout       = la_data_out[31:0];
    assign cbitout    = la_data_out[47:32];

    always #5 clk = ~clk;

    user_proj_example dut (
        .vdda1(vdda1), .vdda2(vdda2), .vssa1(vssa1), .vssa2(vssa2),
        .vccd1(vccd1), .vccd2(vccd2), .vssd1(vssd1), .vssd2(vssd2),
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wbs_stb_i(1'b1),
        .wbs_cyc_i(1'b1),
        .wbs_we_i(1'b1),
        .wbs_sel_i(4'hF),
        .wbs_dat_i(32'hDEADBEEF),
        .wbs_adr_i(32'h3000_0000),
        .wbs_ack_o(wbs_ack),
        .wbs_dat_o(wbs_dat),
        .la_data_in(la_data_in),
        .la_data_out(la_data_out),
        .la_oen(128'h0),
        .io_in(38'h2A_AAAA_AAAA),
        .io_out(io_out),
        .io_oeb(io_oeb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [15:0] w);
        cbitin    = w;
        cfg_shift = 1'b1;
        tick();
        cfg_shift = 1'b0;
    endtask

    // Loads the types array: row 15's b2 goes in first, row 0's b0 last.
    task automatic load_types();
        for (int k = 0; k < 48; k++) begin
            for (int c = 0; c < 16; c++)
                cbitin[c] = types[15 - k/3][c][2 - k%3];
            cfg_shift = 1'b1;
            tick();
        end
        cfg_shift = 1'b0;
        cbitin    = '0;
    endtask

    task automatic fill_types(input logic [2:0] t);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                types[r][c] = t;
    endtask

    task automatic apply_vin(input logic [31:0] v);
        vin = v;
        tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        vin       = 32'hFFFF_FFFF;
        cbitin    = 16'hFFFF;
        cfg_shift = 1'b1;
        cfg_clear = 1'b0;
        ign_hi    = 14'h2BCD;
        ign_lo    = 64'hA5A5_5A5A_0F0F_F0F0;
        tick();
        tick();
        checks++;
        if (la_data_out !== 128'd0) begin
            errors++;
            $display("FAIL reset_la_out: got %h expected 0", la_data_out);
        end
        checks++;
        if (io_oeb !== {38{1'b1}}) begin
            errors++;
            $display("FAIL reset_io_oeb: got %h expected all ones", io_oeb);
        end
        checks++;
        if (wbs_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_wbs_ack: got %b expected 0", wbs_ack);
        end
        checks++;
        if (wbs_dat !== 32'd0) begin
            errors++;
            $display("FAIL reset_wbs_dat: got %h expected 0", wbs_dat);
        end
        checks++;
        if (io_out !== 38'd0) begin
            errors++;
            $display("FAIL reset_io_out: got %h expected 0", io_out);
        end
        cfg_shift = 1'b0;
        cbitin    = '0;
        vin       = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_vertical();
        for (int i = 0; i < 16; i++) begin
            shift_word(16'h0000);
            shift_word(16'h0000);
            shift_word(16'hFFFF);
        end
        apply_vin(32'h5A5A_A5A5);
        checks++;
        if (vout !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL vert_vout: got %h expected 5a5aa5a5", vout);
        end
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL vert_cbitout: got %h expected 0000", cbitout);
        end
        checks++;
        if (la_data_out[127:48] !== 80'd0) begin
            errors++;
            $display("FAIL vert_upper: got %h expected 0", la_data_out[127:48]);
        end
        shift_word(16'h0000);
        shift_word(16'h0000);
        checks++;
        if (cbitout !== 16'hFFFF) begin
            errors++;
            $display("FAIL vert_cbitout_shift2: got %h expected ffff", cbitout);
        end
    endtask

    task automatic test_clear_priority();
        cbitin    = 16'hFFFF;
        cfg_clear = 1'b1;
        cfg_shift = 1'b1;
        tick();
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL clear_cbitout_edge: got %h expected 0000", cbitout);
        end
        cfg_clear = 1'b0;
        cfg_shift = 1'b0;
        cbitin    = '0;
        tick();
        checks++;
        if (vout !== 32'h0000_0000) begin
            errors++;
            $display("FAIL clear_vout: got %h expected 00000000", vout);
        end
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL clear_cbitout: got %h expected 0000", cbitout);
        end
    endtask

    task automatic test_product_term();
        fill_types(3'd0);
        for (int c = 0; c < 15; c++)
            types[0][c] = 3'd4;
        types[0][15] = 3'd6;
        for (int r = 1; r < 16; r++)
            types[r][15] = 3'd1;
        load_types();
        apply_vin(32'hAAAA_AAAA);
        checks++;
        if (vout !== 32'h8000_0000) begin
            errors++;
            $display("FAIL and_all_true: got %h expected 80000000", vout);
        end
        apply_vin(32'hAAAA_AA6A);
        checks++;
        if (vout !== 32'h4000_0000) begin
            errors++;
            $display("FAIL and_col3_false: got %h expected 40000000", vout);
        end
        apply_vin(32'hAAAA_AA2A);
        checks++;
        if (vout !== 32'h0000_0000) begin
            errors++;
            $display("FAIL and_col3_empty: got %h expected 00000000", vout);
        end
    endtask

    task automatic test_n_cell();
        fill_types(3'd0);
        types[0][0] = 3'd5;
        types[0][1] = 3'd6;
        for (int r = 1; r < 16; r++)
            types[r][1] = 3'd1;
        load_types();
        apply_vin(32'h0000_0001);
        checks++;
        if (vout !== 32'h0000_0008) begin
            errors++;
            $display("FAIL n_in_false: got %h expected 00000008", vout);
        end
        apply_vin(32'h0000_0002);
        checks++;
        if (vout !== 32'h0000_0004) begin
            errors++;
            $display("FAIL n_in_true: got %h expected 00000004", vout);
        end
        apply_vin(32'h0000_0003);
        checks++;
        if (vout !== 32'h0000_0000) begin
            errors++;
            $display("FAIL n_in_invalid: got %h expected 00000000", vout);
        end
    endtask

    task automatic test_invalid_hold();
        fill_types(3'd1);
        load_types();
        apply_vin(32'h5A5A_A5A7);
        checks++;
        if (vout !== 32'h5A5A_A5A4) begin
            errors++;
            $display("FAIL invalid_code: got %h expected 5a5aa5a4", vout);
        end
        for (int i = 0; i < 10; i++) begin
            cbitin = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            tick();
        end
        cbitin = '0;
        checks++;
        if (vout !== 32'h5A5A_A5A4) begin
            errors++;
            $display("FAIL hold_vout: got %h expected 5a5aa5a4", vout);
        end
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL hold_cbitout: got %h expected 0000", cbitout);
        end
    endtask

    task automatic test_midload_reset();
        fill_types(3'd7);
        load_types();
        checks++;
        if (cbitout !== 16'hFFFF) begin
            errors++;
            $display("FAIL preload_cbitout: got %h expected ffff", cbitout);
        end
        vin = 32'h5A5A_A5A5;
        for (int i = 0; i < 20; i++)
            shift_word(16'h0000);
        checks++;
        if (cbitout !== 16'hFFFF) begin
            errors++;
            $display("FAIL partial_cbitout: got %h expected ffff", cbitout);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst_cbitout: got %h expected 0000", cbitout);
        end
        checks++;
        if (la_data_out !== 128'd0) begin
            errors++;
            $display("FAIL async_rst_la_out: got %h expected 0", la_data_out);
        end
        tick();
        rst = 1'b0;
        tick();
        fill_types(3'd1);
        types[7][2] = 3'd0;
        types[3][9] = 3'd5;
        load_types();
        apply_vin(32'h5A5A_A5A5);
        checks++;
        if (vout !== 32'h5A5A_A585) begin
            errors++;
            $display("FAIL reload_vout: got %h expected 5a5aa585", vout);
        end
        checks++;
        if (cbitout !== 16'h0000) begin
            errors++;
            $display("FAIL reload_cbitout: got %h expected 0000", cbitout);
        end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_clear_priority();
        test_product_term();
        test_n_cell();
        test_invalid_hold();
        test_midload_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
